store_buffer: RTL and testbench

Posted-write store buffer between the MEM stage and the single-port data RAM. It absorbs MEM-stage stores into a small FIFO and drains them to the RAM in cycles when the MEM stage is not using memory. Loads read the RAM combinationally, with bytes from still-buffered stores merged in (store-to-load forwarding). When a store arrives and the buffer is full, the block raises a stall request to the pipeline controller.

---
 rtl/store_buffer.sv | 133 +++++++++++++
 tb/tb_store_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write store buffer between the MEM stage and the
// single-port data RAM. MEM-stage stores are queued in a small FIFO and
// written to the RAM in cycles where the MEM stage does not use memory.
// Loads read the RAM combinationally. Bytes from stores that are still
// buffered are merged into the load result, with the youngest store winning.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   mem_ce_i, mem_we_i       MEM-stage access valid / store(1) or load(0)
//   mem_addr_i, mem_sel_i    byte address and byte-lane enables
//   mem_data_i, mem_data_o   store data in / load result out
//   stallreq_o               store presented while the buffer is full
//   empty_o                  buffer holds no entries
//   ram_*_o, ram_data_i      data RAM port (combinational read data)
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_ce_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [3:0]    mem_sel_i,
    input  logic [DW-1:0] mem_data_i,
    output logic [DW-1:0] mem_data_o,
    output logic          stallreq_o,
    output logic          empty_o,
    output logic          ram_ce_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [3:0]    ram_sel_o,
    output logic [DW-1:0] ram_data_o,
    input  logic [DW-1:0] ram_data_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = DW / 4;

    logic [AW-3:0] ent_waddr [DEPTH];
    logic [3:0]    ent_sel   [DEPTH];
    logic [DW-1:0] ent_data  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic is_load;
    logic is_store;
    logic nop_store;
    logic full;
    logic enq;
    logic drain;

    assign is_load    = mem_ce_i & ~mem_we_i;
    assign is_store   = mem_ce_i & mem_we_i & (mem_sel_i != 4'b0000);
    assign nop_store  = mem_ce_i & mem_we_i & (mem_sel_i == 4'b0000);
    assign full       = (count == (PW+1)'(DEPTH));
    assign stallreq_o = is_store & full;
    assign enq        = is_store & ~full;
    // A stalled store frees a slot by draining in the same cycle, so a full
    // event costs exactly one stall cycle.
    assign drain      = (count != '0) & (~mem_ce_i | nop_store | stallreq_o);
    assign empty_o    = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail  <= tail + PW'(1);
                count <= count + (PW+1)'(1);
            end else if (drain) begin
                count <= count - (PW+1)'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
        end
    end

    // Payloads are left untouched by reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_waddr[tail] <= mem_addr_i[AW-1:2];
            ent_sel[tail]   <= mem_sel_i;
            ent_data[tail]  <= mem_data_i;
        end
    end

    // Walk entries oldest to youngest relative to head so that younger
    // matches overwrite older ones lane by lane, independent of pointer wrap.
    logic [DW-1:0] fwd;
    logic [PW-1:0] idx;
    always_comb begin
        fwd = ram_data_i;
        idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + i[PW-1:0];
            if (((PW+1)'(i) < count) && (ent_waddr[idx] == mem_addr_i[AW-1:2])) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (ent_sel[idx][k]) begin
                        fwd[k*LW +: LW] = ent_data[idx][k*LW +: LW];
                    end
                end
            end
        end
        mem_data_o = is_load ? fwd : '0;
    end

    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_sel_o  = '0;
        ram_data_o = '0;
        if (is_load) begin
            ram_ce_o   = 1'b1;
            ram_addr_o = mem_addr_i;
            ram_sel_o  = mem_sel_i;
        end else if (drain) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = 1'b1;
            ram_addr_o = {ent_waddr[head], 2'b00};
            ram_sel_o  = ent_sel[head];
            ram_data_o = ent_data[head];
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        stallreq_o;
    logic        empty_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .stallreq_o (stallreq_o),
        .empty_o    (empty_o),
        .ram_ce_o   (ram_ce_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_sel_o  (ram_sel_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data RAM: 256 words, combinational read.
    logic [31:0] ram_m [256];
    assign ram_data_i = ram_m[ram_addr_o[9:2]];

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } wr_t;

    wr_t sbq[$];
    int  mcount;
    int  n_cmp;
    int  n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // then clock and update the model RAM / occupancy.
    task automatic cyc(input logic ce, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input logic ldchk, input logic [31:0] ldexp);
        logic st, xfull, xstall, xenq, xdrain, cwe;
        logic [31:0] ca, cd;
        logic [3:0] cs;
        wr_t e;
        mem_ce_i = ce; mem_we_i = we; mem_addr_i = a; mem_sel_i = s; mem_data_i = d;
        #1;
        st     = ce && we && (s != 4'b0000);
        xfull  = (mcount == 4);
        xstall = st && xfull;
        xenq   = st && !xfull;
        xdrain = (mcount != 0) && (!ce || (we && s == 4'b0000) || xstall);
        chk("stallreq", 32'(stallreq_o), 32'(xstall));
        chk("empty", 32'(empty_o), 32'(mcount == 0));
        chk("ram_we", 32'(ram_we_o), 32'(xdrain));
        if (xdrain) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'(1), 32'(0));
            end else begin
                e = sbq.pop_front();
                chk("drain_ce", 32'(ram_ce_o), 32'(1));
                chk("drain_addr", ram_addr_o, e.a);
                chk("drain_sel", 32'(ram_sel_o), 32'(e.s));
                chk("drain_data", ram_data_o, e.d);
            end
        end else if (ce && !we) begin
            chk("load_ce", 32'(ram_ce_o), 32'(1));
            chk("load_addr", ram_addr_o, a);
        end else begin
            chk("idle_ce", 32'(ram_ce_o), 32'(0));
            chk("idle_addr", ram_addr_o, 32'(0));
        end
        if (ce && !we) begin
            if (ldchk) chk("load_data", mem_data_o, ldexp);
        end else begin
            chk("nonload_data", mem_data_o, 32'(0));
        end
        if (xenq) sbq.push_back({a & 32'hFFFF_FFFC, s, d});
        cwe = ram_we_o; ca = ram_addr_o; cs = ram_sel_o; cd = ram_data_o;
        @(posedge clk);
        #1;
        if (cwe) begin
            for (int k = 0; k < 4; k++)
                if (cs[k]) ram_m[ca[9:2]][k*8 +: 8] = cd[k*8 +: 8];
        end
        mcount = mcount + (xenq ? 1 : 0) - (xdrain ? 1 : 0);
        @(negedge clk);
    endtask

    task automatic st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, s, d, 1'b0, 32'h0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 4'hF, 32'h0, 1'b1, exp);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; mcount = 0;
        for (int i = 0; i < 256; i++) ram_m[i] = 32'h0;
        ram_m[8'hC0] = 32'h5566_7788;   // word 0x300
        ram_m[8'h80] = 32'h1122_3344;   // word 0x200
        rst = 1'b1;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;

        // Outputs while in reset
        @(negedge clk);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300; mem_sel_i = 4'hF;
        #1;
        chk("rst_load_data", mem_data_o, 32'h5566_7788);
        chk("rst_load_ce", 32'(ram_ce_o), 32'(1));
        chk("rst_we", 32'(ram_we_o), 32'(0));
        chk("rst_empty", 32'(empty_o), 32'(1));
        chk("rst_stall", 32'(stallreq_o), 32'(0));
        mem_we_i = 1'b1; mem_data_i = 32'hFFFF_FFFF;
        #1;
        chk("rst_store_data", mem_data_o, 32'(0));
        chk("rst_store_ce", 32'(ram_ce_o), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Single store then idle
        st(32'h100, 4'hF, 32'hDEAD_BEEF);
        idle();
        chk("single_ram", ram_m[8'h40], 32'hDEAD_BEEF);
        idle();

        // Forwarding merge, youngest wins per lane
        st(32'h200, 4'b0001, 32'h0000_00AA);
        st(32'h200, 4'b0001, 32'h0000_00BB);
        st(32'h200, 4'b0100, 32'h00CC_0000);
        ld(32'h200, 32'h11CC_33BB);
        idle(); idle(); idle();
        ld(32'h200, 32'h11CC_33BB);

        // Full stall: store 5 stalls once, then accepted; wraps into index 0
        st(32'h400, 4'hF, 32'h1111_1111);
        st(32'h404, 4'hF, 32'h2222_2222);
        st(32'h408, 4'hF, 32'h3333_3333);
        st(32'h40C, 4'hF, 32'h4444_4444);
        st(32'h40C, 4'b0011, 32'h0000_5555);
        st(32'h40C, 4'b0011, 32'h0000_5555);
        // Full plus load across wrap: index 0 is younger than index 3
        ld(32'h40C, 32'h4444_5555);
        ld(32'h404, 32'h2222_2222);
        chk("full_after_load", 32'(empty_o), 32'(0));
        st(32'h500, 4'hF, 32'h0000_0000);   // still full: must stall again
        idle(); idle(); idle(); idle();
        idle();
        ld(32'h40C, 32'h4444_5555);
        ld(32'h408, 32'h3333_3333);

        // sel==0 store with two entries buffered
        st(32'h700, 4'hF, 32'h0000_000A);
        st(32'h704, 4'hF, 32'h0000_000B);
        st(32'h708, 4'b0000, 32'hFFFF_FFFF);
        idle();
        idle();
        chk("sel0_ram", ram_m[8'hC2], 32'h0);

        // Reset mid-operation discards buffered stores
        st(32'h140, 4'hF, 32'hBAD0_0001);
        st(32'h144, 4'hF, 32'hBAD0_0002);
        st(32'h148, 4'hF, 32'hBAD0_0003);
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_empty", 32'(empty_o), 32'(1));
        chk("midrst_we", 32'(ram_we_o), 32'(0));
        @(posedge clk);
        #1;
        chk("midrst_we_edge", 32'(ram_we_o), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        mcount = 0;
        st(32'h180, 4'hF, 32'h600D_600D);
        idle();
        idle();
        chk("midrst_new", ram_m[8'h60], 32'h600D_600D);
        chk("midrst_disc0", ram_m[8'h50], 32'h0);
        chk("midrst_disc2", ram_m[8'h52], 32'h0);
        chk("sb_drained", 32'(sbq.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
